switch_debounce_reader: RTL and testbench
=========================================

// Module: switch_debounce_reader
// PURPOSE
//  Input-side counterpart of the hex-to-7-segment display drivers on the DE2-70 board.
//  - Samples the raw slide-switch nibble that the displays show, synchronises it to clk and debounces it.
//  - Presents a clean hex_digit plus a one-cycle update strobe when a new value has been stable long enough.
//  - Sits between the board switch pins and the display decoder / user logic.
// PARAMETERS
//  WIDTH            4          number of switch bits debounced as one bus
//  DEBOUNCE_CYCLES  1_000_000  clk cycles the synchronised value must stay constant (20 ms at 50 MHz); must be >= 2
//  CNT_W            derived    localparam, $clog2(DEBOUNCE_CYCLES+1)
// PORTS
//  clk         in   1      system clock (50 MHz board clock)
//  rst_n       in   1      asynchronous, active-low reset
//  sw_raw      in   WIDTH  raw switch pins, asynchronous to clk, may bounce
//  hold        in   1      1 = freeze hex_digit, ignore switch changes
//  hex_digit   out  WIDTH  debounced switch value
//  update      out  1      one-cycle pulse, high in the cycle hex_digit takes a new value
//  settling    out  1      high while a candidate value is being timed (state SETTLING)
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops=0, hex_digit=0, update=0, settling=0, cnt=0, cand=0, state=STABLE.
//  Synchroniser: two flops, sync1<=sw_raw, sync2<=sync1; the FSM sees only sync2.
//  FSM states STABLE, SETTLING. update defaults to 0 every cycle.
//   STABLE:
//    - if !hold and sync2!=hex_digit: cand<=sync2, cnt<=1, go SETTLING.
//    - else stay.
//   SETTLING:
//    - hold=1: go STABLE, discard cand, no update (hold beats completion on the same edge).
//    - sync2==hex_digit: abort to STABLE, no update (glitch rejected).
//    - sync2!=cand (and !=hex_digit): cand<=sync2, cnt<=1, stay (restart timing).
//    - sync2==cand and cnt==DEBOUNCE_CYCLES: hex_digit<=cand, update<=1, go STABLE.
//    - sync2==cand and cnt<DEBOUNCE_CYCLES: cnt<=cnt+1.
//  Latency:
//    - sw_raw first sampled stable at edge N -> FSM enters SETTLING at edge N+2.
//    - hex_digit changes and update is high after edge N+2+DEBOUNCE_CYCLES.
//    - Total latency DEBOUNCE_CYCLES+2 cycles.
//  update never pulses when the final value equals the previous hex_digit.
//  A new change accepted straight after an update starts the next SETTLING no earlier than the next edge.
//  Counter never wraps: cnt is bounded by DEBOUNCE_CYCLES, and CNT_W holds DEBOUNCE_CYCLES.
//  hold released with sync2!=hex_digit: SETTLING starts on the first edge hold=0 is sampled, update follows DEBOUNCE_CYCLES edges later.
//  Reset mid-SETTLING: all outputs return to reset values immediately; cand is lost.
//  A non-zero sw_raw at reset release is debounced normally -> update after DEBOUNCE_CYCLES+2 cycles.
//  settling = (state==SETTLING), registered.
// TESTING (bench uses DEBOUNCE_CYCLES=8, WIDTH=4)
//  1. Reset with sw_raw=0, hold=0, run 50 cycles -> hex_digit=0, update=0 and settling=0 throughout.
//  2. sw_raw 0->4'hA clean at edge N -> settling=1 from N+2; hex_digit=4'hA and update=1 after edge N+10, update low at N+11.
//  3. sw_raw alternates 4'hA/4'h5 every 3 cycles for 30 cycles, then holds 4'h5 from edge M
//       -> no update during bouncing; hex_digit=4'h5 with one update pulse after edge M+10.
//  4. hex_digit=4'h5; sw_raw=4'h7 for 4 cycles, then back to 4'h5 -> no update, hex_digit stays 4'h5, settling returns to 0.
//  5. hold=1, sw_raw->4'h3 for 20 cycles -> hex_digit unchanged, settling=0;
//       hold->0 sampled at edge H -> hex_digit=4'h3 and update after edge H+8.
//  6. rst_n pulsed low while settling=1 (sw_raw=4'hC) -> hex_digit=0 and settling=0 asynchronously;
//       after release hex_digit=4'hC after DEBOUNCE_CYCLES+2 cycles.

Source files
------------

// File: rtl/switch_debounce_reader_if.sv
// switch_debounce_reader_if: switch input and debounced digit bus
//   master: drives sw_raw, hold; observes hex_digit, update, settling
//   slave : the debouncer, consumes sw_raw/hold and produces the outputs
interface switch_debounce_reader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw_raw;
  logic             hold;
  logic [WIDTH-1:0] hex_digit;
  logic             update;
  logic             settling;
  modport master (output sw_raw, hold, input hex_digit, update, settling);
  modport slave  (input sw_raw, hold, output hex_digit, update, settling);
endinterface

// File: rtl/switch_debounce_reader.sv
// switch_debounce_reader: synchronise and debounce a raw switch bus into a clean digit
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   bus.sw_raw     raw switch pins, asynchronous, may bounce
//   bus.hold       freezes hex_digit and ignores switch changes
//   bus.hex_digit  debounced value
//   bus.update     one-cycle pulse when hex_digit takes a new value
//   bus.settling   high while a candidate value is being timed
module switch_debounce_reader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                      clk,
  input logic                      rst_n,
  switch_debounce_reader_if.slave  bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  typedef enum logic {STABLE, SETTLING} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_hex;
  logic [CNT_W-1:0] r_cnt;
  logic             r_update, r_settling;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cand     <= '0;
      r_hex      <= '0;
      r_cnt      <= '0;
      r_update   <= 1'b0;
      r_settling <= 1'b0;
      r_state    <= STABLE;
    end else begin
      r_sync1  <= bus.sw_raw;
      r_sync2  <= r_sync1;
      r_update <= 1'b0;
      case (r_state)
        STABLE:
          if (!bus.hold && r_sync2 != r_hex) begin
            r_cand     <= r_sync2;
            r_cnt      <= CNT_W'(1);
            r_state    <= SETTLING;
            r_settling <= 1'b1;
          end
        SETTLING:
          // hold wins over completion; returning to the old value is a rejected glitch
          if (bus.hold || r_sync2 == r_hex) begin
            r_state    <= STABLE;
            r_settling <= 1'b0;
          end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= CNT_W'(1);
          end else if (r_cnt == CNT_MAX) begin
            r_hex      <= r_cand;
            r_update   <= 1'b1;
            r_state    <= STABLE;
            r_settling <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        default: begin
          r_state    <= STABLE;
          r_settling <= 1'b0;
        end
      endcase
    end
  end
  assign bus.hex_digit = r_hex;
  assign bus.update    = r_update;
  assign bus.settling  = r_settling;
endmodule

// File: tb/tb_switch_debounce_reader.sv
// tb_switch_debounce_reader: directed checks of the switch debouncer with DEBOUNCE_CYCLES=8
module tb_switch_debounce_reader;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  switch_debounce_reader_if #(.WIDTH(W)) bus ();
  switch_debounce_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] hex, input logic upd, input logic set);
    chk(tag, {2'b0, bus.hex_digit, bus.update, bus.settling}, {2'b0, hex, upd, set});
  endtask
  initial begin
    bus.sw_raw = 4'h0;
    bus.hold   = 1'b0;
    // 1: reset and idle
    tick(); tick();
    chk_out("reset", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_out("idle", 4'h0, 1'b0, 1'b0);
    end
    // 2: clean change 0 -> A
    bus.sw_raw = 4'hA;
    tick(); tick();
    chk_out("t2_n1", 4'h0, 1'b0, 1'b0);
    tick();
    chk_out("t2_n2", 4'h0, 1'b0, 1'b1);
    repeat (7) tick();
    chk_out("t2_n9", 4'h0, 1'b0, 1'b1);
    tick();
    chk_out("t2_n10", 4'hA, 1'b1, 1'b0);
    tick();
    chk_out("t2_n11", 4'hA, 1'b0, 1'b0);
    // 3: bounce A/5 every 3 cycles, then settle on 5
    for (int i = 0; i < 10; i++) begin
      bus.sw_raw = (i % 2 == 0) ? 4'h5 : 4'hA;
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("t3_bounce", {3'b0, bus.hex_digit, bus.update}, {3'b0, 4'hA, 1'b0});
      end
    end
    bus.sw_raw = 4'h5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_wait", {3'b0, bus.hex_digit, bus.update}, {3'b0, 4'hA, 1'b0});
    end
    tick();
    chk_out("t3_m10", 4'h5, 1'b1, 1'b0);
    tick();
    chk_out("t3_m11", 4'h5, 1'b0, 1'b0);
    // 4: short glitch to 7 is rejected
    bus.sw_raw = 4'h7;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) chk_out("t4_settle", 4'h5, 1'b0, 1'b1);
    end
    bus.sw_raw = 4'h5;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4_noupd", {3'b0, bus.hex_digit, bus.update}, {3'b0, 4'h5, 1'b0});
    end
    chk_out("t4_end", 4'h5, 1'b0, 1'b0);
    // 5: hold freezes, release starts timing
    bus.hold   = 1'b1;
    bus.sw_raw = 4'h3;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("t5_hold", 4'h5, 1'b0, 1'b0);
    end
    bus.hold = 1'b0;
    tick();
    chk_out("t5_h0", 4'h5, 1'b0, 1'b1);
    repeat (7) tick();
    chk_out("t5_h7", 4'h5, 1'b0, 1'b1);
    tick();
    chk_out("t5_h8", 4'h3, 1'b1, 1'b0);
    tick();
    chk_out("t5_h9", 4'h3, 1'b0, 1'b0);
    // 6: async reset mid-settling
    bus.sw_raw = 4'hC;
    repeat (3) tick();
    chk_out("t6_settle", 4'h3, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("t6_async", 4'h0, 1'b0, 1'b0);
    tick();
    chk_out("t6_inrst", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk_out("t6_r1", 4'h0, 1'b0, 1'b0);
    tick();
    chk_out("t6_r2", 4'h0, 1'b0, 1'b1);
    repeat (7) tick();
    chk_out("t6_r9", 4'h0, 1'b0, 1'b1);
    tick();
    chk_out("t6_r10", 4'hC, 1'b1, 1'b0);
    tick();
    chk_out("t6_r11", 4'hC, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
